// File: rtl/dl_origin_arbiter.sv
// Central arbiter of the deadlock-detection token ring: picks an origin process,
// waits for its token to return, confirms the cycle and latches the deadlock report.
module dl_origin_arbiter #(
  parameter int PROC_NUM       = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] proc_blocked_vec,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_detect_out,
  output logic [ID_W-1:0]     dl_proc_id,
  output logic                report_valid,
  input  logic                report_ack
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW = $clog2(CONFIRM_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CONFIRM, CLEAR, DETECTED} state_t;

  state_t                state;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       pick;
  logic                  found;
  int unsigned           scan;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         confirm_cnt;
  logic [PROC_NUM-1:0]   cand_onehot;
  logic                  cand_blocked;
  logic                  cand_hit;

  assign cand_blocked = proc_blocked_vec[cand];
  assign cand_hit     = dl_in_vec[cand];

  // Round-robin scan starting at rr_ptr, wrapping past PROC_NUM-1 back to 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = 0;
    for (int unsigned k = 0; k < PROC_NUM; k++) begin
      scan = (32'(rr_ptr) + k) % PROC_NUM;
      if (!found && proc_blocked_vec[scan[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    cand_onehot       = '0;
    cand_onehot[cand] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cand          <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      confirm_cnt   <= '0;
      origin        <= '0;
      token_clear   <= 1'b0;
      dl_detect_out <= 1'b0;
      dl_proc_id    <= '0;
      report_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cand  <= pick;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          origin <= cand_onehot;
          timer  <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!cand_blocked) begin
            state       <= CLEAR;
            token_clear <= 1'b1;
            origin      <= '0;
          end else if (cand_hit) begin
            confirm_cnt <= CW'(1);
            // A single confirm cycle is satisfied by the returning token itself.
            if (CONFIRM_CYCLES == 1) begin
              state         <= DETECTED;
              dl_detect_out <= 1'b1;
              dl_proc_id    <= cand;
              report_valid  <= 1'b1;
            end else begin
              state <= CONFIRM;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= CLEAR;
            token_clear <= 1'b1;
            origin      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CONFIRM: begin
          if (cand_hit && cand_blocked) begin
            confirm_cnt <= confirm_cnt + 1'b1;
            if (confirm_cnt + 1'b1 == CW'(CONFIRM_CYCLES)) begin
              state         <= DETECTED;
              dl_detect_out <= 1'b1;
              dl_proc_id    <= cand;
              report_valid  <= 1'b1;
            end
          end else begin
            state       <= CLEAR;
            token_clear <= 1'b1;
            origin      <= '0;
          end
        end
        CLEAR: begin
          token_clear <= 1'b0;
          rr_ptr      <= (cand == ID_W'(PROC_NUM - 1)) ? '0 : cand + 1'b1;
          state       <= IDLE;
        end
        DETECTED: begin
          if (report_ack) report_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_origin_arbiter.sv
// Bench for dl_origin_arbiter: vector table, directed corner sequences and a
// randomized run against an attempt-level reference model, on two parameterisations.
module tb_dl_origin_arbiter;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: PROC_NUM=2, CONFIRM=4, TIMEOUT=16
  logic       rst_a = 1'b0, ack_a = 1'b0;
  logic [1:0] blk_a = '0, dl_a = '0;
  logic [1:0] origin_a;
  logic       tc_a, det_a, rv_a;
  logic [0:0] id_a;

  // Instance B: PROC_NUM=4, CONFIRM=1, TIMEOUT=4
  logic       rst_b = 1'b0, ack_b = 1'b0;
  logic [3:0] blk_b = '0, dl_b = '0;
  logic [3:0] origin_b;
  logic       tc_b, det_b, rv_b;
  logic [1:0] id_b;

  dl_origin_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(4), .TIMEOUT_CYCLES(16)) u_a (
    .clock(clock), .reset(rst_a), .proc_blocked_vec(blk_a), .dl_in_vec(dl_a),
    .origin(origin_a), .token_clear(tc_a), .dl_detect_out(det_a), .dl_proc_id(id_a),
    .report_valid(rv_a), .report_ack(ack_a));

  dl_origin_arbiter #(.PROC_NUM(4), .CONFIRM_CYCLES(1), .TIMEOUT_CYCLES(4)) u_b (
    .clock(clock), .reset(rst_b), .proc_blocked_vec(blk_b), .dl_in_vec(dl_b),
    .origin(origin_b), .token_clear(tc_b), .dl_detect_out(det_b), .dl_proc_id(id_b),
    .report_valid(rv_b), .report_ack(ack_b));

  int checks = 0;
  int errors = 0;

  // Attempt-level model: candidate, whether origin is armed, cycles waited,
  // consecutive confirmed returns, and a one-cycle cool-down after an abort.
  typedef struct packed {
    int         cand;
    int         rr;
    int         age;
    int         streak;
    logic       armed;
    logic       cool;
    logic [3:0] origin;
    logic       clr;
    logic       det;
    logic [1:0] id;
    logic       rep;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, int p, int c, int t, logic rst,
                                    logic [3:0] blk, logic [3:0] dl, logic ack);
    mstate_t n = s;
    logic live, hit, abort, win;
    live = 1'b0; hit = 1'b0; abort = 1'b0; win = 1'b0;
    if (!rst) begin
      n = '0;
      n.cand = -1;
      return n;
    end
    if (s.det) begin
      if (ack) n.rep = 1'b0;
    end else if (s.cool) begin
      n.cool = 1'b0;
      n.clr  = 1'b0;
      n.rr   = (s.cand + 1) % p;
      n.cand = -1;
    end else if (s.cand < 0) begin
      for (int k = p - 1; k >= 0; k--)
        if (blk[(s.rr + k) % p]) n.cand = (s.rr + k) % p;
      n.armed = 1'b0;
    end else if (!s.armed) begin
      n.armed  = 1'b1;
      n.origin = 4'(1 << s.cand);
      n.age    = 0;
      n.streak = 0;
    end else begin
      live = blk[s.cand];
      hit  = dl[s.cand];
      if (s.streak == 0) begin
        if (!live) abort = 1'b1;
        else if (hit) begin
          n.streak = 1;
          win = (c == 1);
        end else if (s.age == t - 1) abort = 1'b1;
        else n.age = s.age + 1;
      end else if (live && hit) begin
        n.streak = s.streak + 1;
        win = (n.streak == c);
      end else abort = 1'b1;
      if (abort) begin
        n.clr = 1'b1; n.origin = '0; n.cool = 1'b1; n.armed = 1'b0;
      end
      if (win) begin
        n.det = 1'b1; n.id = 2'(s.cand); n.rep = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    ma = mstep(ma, 2, 4, 16, rst_a, {2'b00, blk_a}, {2'b00, dl_a}, ack_a);
    mb = mstep(mb, 4, 1, 4, rst_b, blk_b, dl_b, ack_b);
    #1;
    chk("model_a", 16'({origin_a, tc_a, det_a, 1'b0, id_a, rv_a}),
        16'({ma.origin[1:0], ma.clr, ma.det, ma.id, ma.rep}));
    chk("model_b", 16'({origin_b, tc_b, det_b, id_b, rv_b}),
        16'({mb.origin, mb.clr, mb.det, mb.id, mb.rep}));
  endtask

  task automatic set_a(input logic r, input logic [1:0] b, input logic [1:0] d, input logic k);
    rst_a = r; blk_a = b; dl_a = d; ack_a = k;
  endtask

  typedef struct packed {
    logic       rst;
    logic [1:0] blk;
    logic [1:0] dl;
    logic       ack;
    logic [1:0] origin;
    logic       clr;
    logic       det;
    logic       id;
    logic       rep;
  } vec_t;

  vec_t tbl[19];
  logic [1:0] exp_o;
  int n;
  logic seen;

  initial begin
    //             rst  blk    dl     ack   origin clr   det   id    rep
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};

    ma = '0; ma.cand = -1;
    mb = '0; mb.cand = -1;
    step();
    rst_b = 1'b1;

    for (int i = 0; i < 19; i++) begin
      set_a(tbl[i].rst, tbl[i].blk, tbl[i].dl, tbl[i].ack);
      step();
      chk($sformatf("tbl_%0d", i), 16'({origin_a, tc_a, det_a, id_a, rv_a}),
          16'({tbl[i].origin, tbl[i].clr, tbl[i].det, tbl[i].id, tbl[i].rep}));
    end

    // Reset while confirming, then while detected: everything clears, no pulse.
    set_a(1'b0, 2'b01, 2'b01, 1'b0); step();
    chk("rst_confirm", 16'({origin_a, tc_a, det_a, rv_a}), 16'h0);
    set_a(1'b1, 2'b00, 2'b00, 1'b0); step();
    chk("rst_confirm_noclr", 16'({origin_a, tc_a}), 16'h0);
    set_a(1'b1, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_detect", 16'({det_a, rv_a}), 16'b11);
    set_a(1'b0, 2'b01, 2'b01, 1'b0); step();
    chk("rst_detected", 16'({origin_a, tc_a, det_a, id_a, rv_a}), 16'h0);

    // Both blocked, token never returns: timeout and alternate origins.
    set_a(1'b1, 2'b11, 2'b00, 1'b0);
    for (int a = 0; a < 3; a++) begin
      exp_o = (a % 2 == 0) ? 2'b01 : 2'b10;
      step();
      n = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        if (origin_a == exp_o) n++;
        if (tc_a) seen = 1'b1;
      end
      chk($sformatf("timeout_len_%0d", a), 16'(n), 16'd16);
      chk($sformatf("timeout_clr_%0d", a), 16'({seen, origin_a}), 16'b100);
      step();
      chk($sformatf("clr_pulse_%0d", a), 16'(tc_a), 16'd0);
    end

    // Confirm broken after two returned cycles on origin 1.
    set_a(1'b0, 2'b00, 2'b00, 1'b0); step();
    set_a(1'b1, 2'b10, 2'b00, 1'b0); step(); step();
    chk("brk_origin", 16'(origin_a), 16'b10);
    dl_a = 2'b10; step(); step();
    dl_a = 2'b00; step();
    chk("brk_clear", 16'({origin_a, tc_a, det_a}), 16'b0010);
    step();
    chk("brk_pulse_end", 16'(tc_a), 16'd0);
    blk_a = 2'b11; step(); step();
    chk("brk_rr_wrap", 16'(origin_a), 16'b01);

    // Four processes: push rr_ptr to 3, then wrap-around picks process 0; CONFIRM=1.
    rst_b = 1'b0; step();
    rst_b = 1'b1; blk_b = 4'b0100; step(); step();
    chk("b_origin2", 16'(origin_b), 16'b0100);
    blk_b = 4'b0001; step();
    chk("b_abort", 16'({origin_b, tc_b}), 16'b00001);
    blk_b = 4'b0101; step(); step(); step();
    chk("b_wrap_origin", 16'(origin_b), 16'b0001);
    dl_b = 4'b0001; step();
    chk("b_detect_c1", 16'({det_b, id_b, rv_b}), 16'b1001);

    // Randomized traffic against the model on both instances.
    for (int i = 0; i < 4000; i++) begin
      rst_a = ($urandom_range(0, 99) != 0);
      rst_b = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 7) == 0) blk_a = 2'($urandom);
      if ($urandom_range(0, 5) == 0) blk_b = 4'($urandom);
      dl_a  = 2'($urandom | $urandom);
      dl_b  = 4'($urandom & $urandom);
      ack_a = ($urandom_range(0, 3) == 0);
      ack_b = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
